// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline and the hazard unit: ID/EX/MEM/WB observation inputs,
// stall/flush/bubble controls, forwarding selects and statistics counters.
interface hazard_if;
    logic [3:0]  rn_id, rm_id, rd_id;
    logic        use_rn, use_rm, use_rd;
    logic [3:0]  rd_ex, rd_mem, rd_wb;
    logic        rf_le_ex, rf_le_mem, rf_le_wb;
    logic        load_ex;
    logic        mem_busy;
    logic        branch_taken;
    logic        stats_clr;
    logic        nop_sel, pc_le, ifid_le, ifid_clr, pipe_hold;
    logic [1:0]  fwd_a, fwd_b, fwd_c;
    logic [15:0] stall_cnt, bubble_cnt;

    modport master (
        output rn_id, rm_id, rd_id, use_rn, use_rm, use_rd,
               rd_ex, rd_mem, rd_wb, rf_le_ex, rf_le_mem, rf_le_wb,
               load_ex, mem_busy, branch_taken, stats_clr,
        input  nop_sel, pc_le, ifid_le, ifid_clr, pipe_hold,
               fwd_a, fwd_b, fwd_c, stall_cnt, bubble_cnt
    );

    modport slave (
        input  rn_id, rm_id, rd_id, use_rn, use_rm, use_rd,
               rd_ex, rd_mem, rd_wb, rf_le_ex, rf_le_mem, rf_le_wb,
               load_ex, mem_busy, branch_taken, stats_clr,
        output nop_sel, pc_le, ifid_le, ifid_clr, pipe_hold,
               fwd_a, fwd_b, fwd_c, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / memory-wait / branch hazard controller with EX operand forwarding.
// Optional statistics counters are built only when HAZ_STATS_EN is defined.
module hazard_unit #(
    parameter int         LOAD_LAT = 1,
    parameter logic [3:0] PC_REG   = 4'd15
) (
    input  logic clk,
    input  logic reset_n,
    hazard_if.slave hif
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] LC_LAT_M1 = 3'(LOAD_LAT - 1);

    state_t     r_state;
    logic [2:0] r_stall_left;

    logic       w_load_use, w_ex_fwd_ok;
    logic       w_nop, w_pc_le, w_ifid_le, w_ifid_clr, w_hold;
    logic [1:0] w_fwd_a, w_fwd_b, w_fwd_c;

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,    input logic used,
        input logic       ex_ok,  input logic [3:0] ex_rd,
        input logic       mem_le, input logic [3:0] mem_rd,
        input logic       wb_le,  input logic [3:0] wb_rd
    );
        if (!used || src == PC_REG) return 2'b00;
        if (ex_ok && ex_rd == src)  return 2'b01;
        if (mem_le && mem_rd == src) return 2'b10;
        if (wb_le && wb_rd == src)  return 2'b11;
        return 2'b00;
    endfunction

    // A load in EX has no data yet, so it never forwards from EX.
    assign w_ex_fwd_ok = hif.rf_le_ex & ~hif.load_ex;

    assign w_fwd_a = fwd_sel(hif.rn_id, hif.use_rn, w_ex_fwd_ok, hif.rd_ex,
                             hif.rf_le_mem, hif.rd_mem, hif.rf_le_wb, hif.rd_wb);
    assign w_fwd_b = fwd_sel(hif.rm_id, hif.use_rm, w_ex_fwd_ok, hif.rd_ex,
                             hif.rf_le_mem, hif.rd_mem, hif.rf_le_wb, hif.rd_wb);
    assign w_fwd_c = fwd_sel(hif.rd_id, hif.use_rd, w_ex_fwd_ok, hif.rd_ex,
                             hif.rf_le_mem, hif.rd_mem, hif.rf_le_wb, hif.rd_wb);

    assign w_load_use = hif.load_ex & hif.rf_le_ex & (hif.rd_ex != PC_REG) &
                        ((hif.use_rn & (hif.rn_id == hif.rd_ex)) |
                         (hif.use_rm & (hif.rm_id == hif.rd_ex)) |
                         (hif.use_rd & (hif.rd_id == hif.rd_ex)));

    always_comb begin
        w_nop      = 1'b0;
        w_pc_le    = 1'b1;
        w_ifid_le  = 1'b1;
        w_ifid_clr = 1'b0;
        w_hold     = 1'b0;
        case (r_state)
            RUN: begin
                if (hif.mem_busy) begin
                    w_hold = 1'b1; w_pc_le = 1'b0; w_ifid_le = 1'b0;
                end else if (w_load_use) begin
                    w_nop = 1'b1; w_pc_le = 1'b0; w_ifid_le = 1'b0;
                end else if (hif.branch_taken) begin
                    w_ifid_clr = 1'b1;
                end
            end
            LOAD_STALL: begin
                w_nop = 1'b1; w_pc_le = 1'b0; w_ifid_le = 1'b0;
            end
            MEM_WAIT: begin
                // Release cycle keeps bubbling if a load stall is still pending.
                if (hif.mem_busy) begin
                    w_hold = 1'b1; w_pc_le = 1'b0; w_ifid_le = 1'b0;
                end else if (r_stall_left != 3'd0) begin
                    w_nop = 1'b1; w_pc_le = 1'b0; w_ifid_le = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RUN;
            r_stall_left <= 3'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (hif.mem_busy) begin
                        r_state <= MEM_WAIT;
                    end else if (w_load_use && (LOAD_LAT > 1)) begin
                        r_state      <= LOAD_STALL;
                        r_stall_left <= LC_LAT_M1;
                    end
                end
                LOAD_STALL: begin
                    if (hif.mem_busy) begin
                        r_state <= MEM_WAIT;
                    end else if (r_stall_left == 3'd1) begin
                        r_state      <= RUN;
                        r_stall_left <= 3'd0;
                    end else begin
                        r_stall_left <= r_stall_left - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!hif.mem_busy)
                        r_state <= (r_stall_left != 3'd0) ? LOAD_STALL : RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign hif.nop_sel   = ~reset_n | w_nop;
    assign hif.pc_le     = reset_n & w_pc_le;
    assign hif.ifid_le   = reset_n & w_ifid_le;
    assign hif.ifid_clr  = reset_n & w_ifid_clr;
    assign hif.pipe_hold = reset_n & w_hold;
    assign hif.fwd_a     = reset_n ? w_fwd_a : 2'b00;
    assign hif.fwd_b     = reset_n ? w_fwd_b : 2'b00;
    assign hif.fwd_c     = reset_n ? w_fwd_c : 2'b00;

`ifdef HAZ_STATS_EN
    logic [15:0] r_stall_cnt, r_bubble_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= 16'd0;
            r_bubble_cnt <= 16'd0;
        end else if (hif.stats_clr) begin
            r_stall_cnt  <= 16'd0;
            r_bubble_cnt <= 16'd0;
        end else begin
            if (!w_pc_le && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_nop && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign hif.stall_cnt  = r_stall_cnt;
    assign hif.bubble_cnt = r_bubble_cnt;
`else
    logic w_unused;
    assign w_unused       = hif.stats_clr;
    assign hif.stall_cnt  = 16'd0;
    assign hif.bubble_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances with LOAD_LAT = 1, 2, 3 share one stimulus.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] rn_id, rm_id, rd_id, rd_ex, rd_mem, rd_wb;
    logic use_rn, use_rm, use_rd, rf_le_ex, rf_le_mem, rf_le_wb;
    logic load_ex, mem_busy, branch_taken, stats_clr;
    int n_vec = 0;
    int n_err = 0;

`ifdef HAZ_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd5, EXP_BUBBLE = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0, EXP_BUBBLE = 16'd0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_if hif();
        assign hif.rn_id = rn_id;           assign hif.rm_id = rm_id;
        assign hif.rd_id = rd_id;           assign hif.use_rn = use_rn;
        assign hif.use_rm = use_rm;         assign hif.use_rd = use_rd;
        assign hif.rd_ex = rd_ex;           assign hif.rd_mem = rd_mem;
        assign hif.rd_wb = rd_wb;           assign hif.rf_le_ex = rf_le_ex;
        assign hif.rf_le_mem = rf_le_mem;   assign hif.rf_le_wb = rf_le_wb;
        assign hif.load_ex = load_ex;       assign hif.mem_busy = mem_busy;
        assign hif.branch_taken = branch_taken;
        assign hif.stats_clr = stats_clr;
        hazard_unit #(.LOAD_LAT(g + 1), .PC_REG(4'd15)) u_dut (
            .clk(clk), .reset_n(reset_n), .hif(hif)
        );
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        rn_id = 0; rm_id = 0; rd_id = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
        use_rn = 0; use_rm = 0; use_rd = 0;
        rf_le_ex = 0; rf_le_mem = 0; rf_le_wb = 0;
        load_ex = 0; mem_busy = 0; branch_taken = 0; stats_clr = 0;
    endtask

    task automatic set_load_use();
        clr_in();
        load_ex = 1; rf_le_ex = 1; rd_ex = 5; rn_id = 5; use_rn = 1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        clr_in();
        rn_id = 3; use_rn = 1; rd_ex = 3; rf_le_ex = 1;
        @(negedge clk);
        chk("rst_nop", g_dut[0].hif.nop_sel, 1);
        chk("rst_pc_le", g_dut[0].hif.pc_le, 0);
        chk("rst_ifid_le", g_dut[0].hif.ifid_le, 0);
        chk("rst_ifid_clr", g_dut[0].hif.ifid_clr, 0);
        chk("rst_hold", g_dut[0].hif.pipe_hold, 0);
        chk("rst_fwd_a", g_dut[0].hif.fwd_a, 0);
        chk("rst_stall_cnt", g_dut[1].hif.stall_cnt, 0);
        chk("rst_bubble_cnt", g_dut[1].hif.bubble_cnt, 0);
        nxt();
        reset_n = 1;
        clr_in(); rn_id = 2; use_rn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("run_nop", g_dut[0].hif.nop_sel, 0);
            chk("run_pc_le", g_dut[0].hif.pc_le, 1);
            chk("run_fwd_a", g_dut[0].hif.fwd_a, 0);
            nxt();
        end

        // Forwarding priority
        clr_in(); rd_ex = 3; rd_mem = 3; rf_le_ex = 1; rf_le_mem = 1; rm_id = 3; use_rm = 1;
        @(negedge clk); chk("fwd_b_ex", g_dut[0].hif.fwd_b, 1);
        chk("fwd_b_ex_pc_le", g_dut[0].hif.pc_le, 1);
        nxt(); rf_le_ex = 0;
        @(negedge clk); chk("fwd_b_mem", g_dut[0].hif.fwd_b, 2);
        nxt(); rf_le_mem = 0; rd_wb = 3; rf_le_wb = 1;
        @(negedge clk); chk("fwd_b_wb", g_dut[0].hif.fwd_b, 3);
        nxt(); use_rm = 0;
        @(negedge clk); chk("fwd_b_unused", g_dut[0].hif.fwd_b, 0);
        nxt(); clr_in(); rd_id = 4; use_rd = 1; rd_mem = 4; rf_le_mem = 1;
        @(negedge clk); chk("fwd_c_mem", g_dut[0].hif.fwd_c, 2);
        nxt(); clr_in();
        rn_id = 15; rm_id = 15; rd_id = 15; use_rn = 1; use_rm = 1; use_rd = 1;
        rd_ex = 15; rd_mem = 15; rd_wb = 15; rf_le_ex = 1; rf_le_mem = 1; rf_le_wb = 1;
        @(negedge clk);
        chk("pc_fwd_a", g_dut[0].hif.fwd_a, 0);
        chk("pc_fwd_b", g_dut[0].hif.fwd_b, 0);
        chk("pc_fwd_c", g_dut[0].hif.fwd_c, 0);
        nxt();

        // Load-use: cycle A bubbles everywhere, then the load sits in MEM
        set_load_use();
        @(negedge clk);
        chk("lu1_nop", g_dut[0].hif.nop_sel, 1);
        chk("lu1_pc_le", g_dut[0].hif.pc_le, 0);
        chk("lu1_fwd_a", g_dut[0].hif.fwd_a, 0);
        chk("lu3_nop_a", g_dut[2].hif.nop_sel, 1);
        nxt(); clr_in(); rn_id = 5; use_rn = 1; rd_mem = 5; rf_le_mem = 1;
        @(negedge clk);
        chk("lu1_after_nop", g_dut[0].hif.nop_sel, 0);
        chk("lu1_after_pc_le", g_dut[0].hif.pc_le, 1);
        chk("lu1_after_fwd_a", g_dut[0].hif.fwd_a, 2);
        chk("lu2_nop_b", g_dut[1].hif.nop_sel, 1);
        chk("lu3_nop_b", g_dut[2].hif.nop_sel, 1);
        nxt(); clr_in();
        @(negedge clk);
        chk("lu2_done_nop", g_dut[1].hif.nop_sel, 0);
        chk("lu3_nop_c", g_dut[2].hif.nop_sel, 1);
        chk("lu3_pc_le_c", g_dut[2].hif.pc_le, 0);
        nxt();
        @(negedge clk);
        chk("lu3_done_nop", g_dut[2].hif.nop_sel, 0);
        chk("lu3_done_pc_le", g_dut[2].hif.pc_le, 1);
        nxt();

        // Memory wait for four cycles
        clr_in(); mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mw_hold", g_dut[0].hif.pipe_hold, 1);
            chk("mw_pc_le", g_dut[0].hif.pc_le, 0);
            chk("mw_ifid_le", g_dut[0].hif.ifid_le, 0);
            chk("mw_nop", g_dut[0].hif.nop_sel, 0);
            nxt();
        end
        mem_busy = 0;
        @(negedge clk);
        chk("mw_rel_hold", g_dut[0].hif.pipe_hold, 0);
        chk("mw_rel_pc_le", g_dut[0].hif.pc_le, 1);
        nxt();
        @(negedge clk); chk("mw_run_pc_le", g_dut[2].hif.pc_le, 1);
        nxt();

        // Branches
        clr_in(); branch_taken = 1;
        @(negedge clk);
        chk("br_clr", g_dut[0].hif.ifid_clr, 1);
        chk("br_pc_le", g_dut[0].hif.pc_le, 1);
        chk("br_nop", g_dut[0].hif.nop_sel, 0);
        nxt(); branch_taken = 0;
        @(negedge clk); chk("br_clr_drop", g_dut[0].hif.ifid_clr, 0);
        nxt(); set_load_use(); branch_taken = 1;
        @(negedge clk);
        chk("brlu_clr", g_dut[0].hif.ifid_clr, 0);
        chk("brlu_nop", g_dut[0].hif.nop_sel, 1);
        chk("brlu_pc_le", g_dut[0].hif.pc_le, 0);
        nxt(); clr_in(); branch_taken = 1;
        @(negedge clk);
        chk("brls_clr", g_dut[2].hif.ifid_clr, 0);
        chk("brls_nop", g_dut[2].hif.nop_sel, 1);
        nxt(); clr_in();
        repeat (3) nxt();

        // Statistics on the LOAD_LAT=2 instance
        stats_clr = 1; nxt(); stats_clr = 0;
        @(negedge clk);
        chk("st_clr_stall", g_dut[1].hif.stall_cnt, 0);
        chk("st_clr_bubble", g_dut[1].hif.bubble_cnt, 0);
        nxt(); set_load_use(); nxt(); clr_in(); nxt();
        mem_busy = 1; repeat (3) nxt(); mem_busy = 0;
        @(negedge clk);
        chk("st_stall", g_dut[1].hif.stall_cnt, EXP_STALL);
        chk("st_bubble", g_dut[1].hif.bubble_cnt, EXP_BUBBLE);
        chk("st_rel_pc_le", g_dut[1].hif.pc_le, 1);
        nxt(); stats_clr = 1; nxt(); stats_clr = 0;
        @(negedge clk);
        chk("st_clr2_stall", g_dut[1].hif.stall_cnt, 0);
        chk("st_clr2_bubble", g_dut[1].hif.bubble_cnt, 0);
        nxt(); repeat (3) nxt();

        // Asynchronous reset pulse in the middle of a LOAD_LAT=3 stall
        set_load_use(); nxt(); clr_in();
        @(negedge clk); chk("rs_pre_nop", g_dut[2].hif.nop_sel, 1);
        nxt();
        reset_n = 0; #2; reset_n = 1;
        @(negedge clk);
        chk("rs_nop", g_dut[2].hif.nop_sel, 0);
        chk("rs_pc_le", g_dut[2].hif.pc_le, 1);
        chk("rs_bubble_cnt", g_dut[1].hif.bubble_cnt, 0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller that drives the select input of the control-unit NOP mux. It is the producer of the `sel` that squashes ID-stage control signals to a bubble. It detects load-use hazards, multi-cycle memory waits and taken branches, then issues stall, flush and bubble controls to PC, IF/ID and the control mux. It also generates the EX-stage operand-forwarding selects. It sits beside the ID stage and observes the ID, EX, MEM and WB stages.

Parameters:
LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (range 1-7)
PC_REG, 15, register index that never triggers forwarding or hazards

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous, active-low reset; the block uses one clock only
rn_id, rm_id, rd_id  input  4 each  ID-stage source registers (rd_id is the store-data source)
use_rn, use_rm, use_rd  input  1 each  the ID instruction actually reads that operand
rd_ex, rd_mem, rd_wb  input  4 each  destination register in EX, MEM and WB
rf_le_ex, rf_le_mem, rf_le_wb  input  1 each  register-file write enable in EX, MEM and WB
load_ex  input  1  EX instruction is a load
mem_busy  input  1  data memory has not completed this cycle
branch_taken  input  1  ID-stage branch resolved as taken
nop_sel  output  1  to the control mux select; 1 means insert a NOP
pc_le  output  1  PC load enable
ifid_le  output  1  IF/ID register load enable
ifid_clr  output  1  IF/ID synchronous flush
pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB
fwd_a, fwd_b, fwd_c  output  2 each  forwarding select for Rn, Rm and Rd: 00 = RF, 01 = EX, 10 = MEM, 11 = WB
stall_cnt, bubble_cnt  output  16 each  statistics counters (see Optional Feature)
stats_clr  input  1  synchronous clear of the statistics counters

Behaviour:
- State register, reset asynchronously to RUN. Control outputs are decoded combinationally from the state and the inputs.
- Output values while reset_n=0: nop_sel=1, pc_le=0, ifid_le=0, ifid_clr=0, pipe_hold=0, all fwd=00, counters=0.
- Forwarding is purely combinational and applies in every state.
  - Operand X with use_X=1 and src!=PC_REG selects 01 if rf_le_ex & rd_ex==src & !load_ex.
  - Otherwise it selects 10 if rf_le_mem & rd_mem==src.
  - Otherwise it selects 11 if rf_le_wb & rd_wb==src.
  - Otherwise 00. Priority is EX > MEM > WB. A src of PC_REG always gives 00.
- load_use = load_ex & rf_le_ex & rd_ex!=PC_REG & (any used source equals rd_ex).
- States are RUN, LOAD_STALL and MEM_WAIT. A 3-bit counter stall_left tracks the remaining stall cycles.
- RUN:
  - mem_busy=1 (highest priority): pipe_hold=1, pc_le=0, ifid_le=0, nop_sel=0. Next state MEM_WAIT.
  - else load_use=1: nop_sel=1, pc_le=0, ifid_le=0 in the same cycle. If LOAD_LAT>1, go to LOAD_STALL with stall_left=LOAD_LAT-1; otherwise stay in RUN.
  - else branch_taken=1: ifid_clr=1, pc_le=1, ifid_le=1, nop_sel=0 for one cycle.
  - else normal flow: pc_le=1, ifid_le=1, nop_sel=0, pipe_hold=0.
- LOAD_STALL:
  - Outputs match the load_use response. stall_left decrements each cycle; at stall_left==1, return to RUN.
  - branch_taken is ignored because the branch re-resolves after the stall.
  - mem_busy=1 overrides: go to MEM_WAIT and keep stall_left frozen.
- MEM_WAIT:
  - Outputs match the RUN mem_busy response.
  - On mem_busy=0, return to LOAD_STALL if stall_left!=0, otherwise to RUN.
  - Every other input is ignored while in this state.
- Simultaneous load_use and branch_taken: the stall wins and no flush is issued.
- Reset asserted mid-stall: the FSM returns to RUN immediately and stall_left is cleared.

Optional Feature:
- Macro HAZ_STATS_EN.
- When defined:
  - stall_cnt increments on every cycle with pc_le=0 and reset_n=1.
  - bubble_cnt increments on every cycle with nop_sel=1 and reset_n=1.
  - Both counters saturate at 16'hFFFF and clear on stats_clr (stats_clr takes priority over an increment).
- When undefined: the ports remain, both counters are tied to 0 and stats_clr is ignored.

Test Plan:
- Reset release, then rn_id=2 with use_rn=1 and no writers: nop_sel=0, pc_le=1, fwd_a=00 every cycle. During reset: nop_sel=1, pc_le=0.
- rd_ex=3 and rd_mem=3 (both rf_le=1, load_ex=0), rm_id=3 with use_rm=1: fwd_b=01. Drop rf_le_ex: fwd_b=10. Source 15 in every stage: fwd=00.
- load_ex=1 with rd_ex=5 and rn_id=5 (use_rn=1), LOAD_LAT=1: exactly one cycle of nop_sel=1 and pc_le=0, then fwd_a=10 the next cycle. With LOAD_LAT=3: three consecutive bubble cycles.
- mem_busy high for 4 cycles during RUN: pipe_hold=1 and pc_le=0 for those 4 cycles, nop_sel=0, and RUN resumes the cycle after.
- branch_taken=1 with no hazard: ifid_clr=1 for one cycle. branch_taken together with load_use: ifid_clr=0 and nop_sel=1.
- With HAZ_STATS_EN and LOAD_LAT=2: one load-use plus 3 mem_busy cycles gives stall_cnt=5 and bubble_cnt=2. Pulsing stats_clr gives 0. reset_n pulsed low mid-LOAD_STALL returns to RUN.
